// File: rtl/queue_push_arbiter.sv
// Circular queue whose single write port is shared by two producers through a
// round-robin arbiter; one consumer drains it first-word fall-through.
module queue_push_arbiter #(
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_gnt,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_gnt,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [PTR_WIDTH:0]    count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  head;
    logic [PTR_WIDTH-1:0]  tail;
    logic [PTR_WIDTH:0]    count_q;
    logic                  last_gnt;
    logic                  pop_fire;
    logic                  can_push;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;

    assign count     = count_q;
    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign out_valid = rst_n & ~empty;
    assign out_data  = out_valid ? mem[head] : '0;
    assign pop_fire  = out_valid & out_ready;

    // A full queue can still accept a push when the head leaves in the same cycle.
    assign can_push  = rst_n & ~flush & (~full | pop_fire);

    always_comb begin
        req0_gnt = 1'b0;
        req1_gnt = 1'b0;
        if (can_push) begin
            if (req0_valid && req1_valid) begin
                if (last_gnt) req0_gnt = 1'b1;
                else          req1_gnt = 1'b1;
            end else if (req0_valid) begin
                req0_gnt = 1'b1;
            end else if (req1_valid) begin
                req1_gnt = 1'b1;
            end
        end
    end

    assign push      = req0_gnt | req1_gnt;
    assign push_data = req1_gnt ? req1_data : req0_data;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
            last_gnt <= 1'b1;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail     <= tail + PTR_WIDTH'(1);
                last_gnt <= req1_gnt;
            end
            if (pop_fire) head <= head + PTR_WIDTH'(1);
            if (push && !pop_fire)      count_q <= count_q + (PTR_WIDTH+1)'(1);
            else if (!push && pop_fire) count_q <= count_q - (PTR_WIDTH+1)'(1);
        end
    end

    // Storage carries no reset; push is already suppressed under reset and flush.
    always_ff @(posedge clk_in) begin
        if (push) mem[tail] <= push_data;
    end

endmodule

// File: tb/tb_queue_push_arbiter.sv
// Randomized scoreboard bench for queue_push_arbiter: a queue-based reference
// predicts grants and occupancy, a monitor checks every popped word in order.
module tb_queue_push_arbiter;

    localparam int DEPTH = 4;
    localparam int PW    = 2;
    localparam int DW    = 32;

    logic          clk_in = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          req0_valid = 1'b0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_gnt;
    logic          req1_valid = 1'b0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_gnt;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [PW:0]   count;
    logic          full;
    logic          empty;

    queue_push_arbiter #(.DEPTH(DEPTH), .PTR_WIDTH(PW), .DATA_WIDTH(DW)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_gnt(req0_gnt),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_gnt(req1_gnt),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk_in = ~clk_in;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] sb[$];
    int            last_win = 1;
    bit            clr0 = 1'b0;
    bit            clr1 = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int rdy_pct, input int flush_pct, input int rst_pct, input int vld_pct);
        int  sz;
        bit  pop;
        bit  canp;
        int  win;
        @(negedge clk_in);
        if (clr0) req0_valid = 1'b0;
        if (clr1) req1_valid = 1'b0;
        clr0 = 1'b0;
        clr1 = 1'b0;
        rst_n     = !(int'($urandom_range(99)) < rst_pct);
        flush     = (int'($urandom_range(99)) < flush_pct);
        out_ready = (int'($urandom_range(99)) < rdy_pct);
        if (!req0_valid && int'($urandom_range(99)) < vld_pct) begin
            req0_valid = 1'b1;
            req0_data  = $urandom;
        end
        if (!req1_valid && int'($urandom_range(99)) < vld_pct) begin
            req1_valid = 1'b1;
            req1_data  = $urandom;
        end
        #1;
        sz   = sb.size();
        pop  = rst_n && sz > 0 && out_ready;
        canp = rst_n && !flush && (sz < DEPTH || pop);
        win  = -1;
        if (canp) begin
            if (req0_valid && req1_valid) win = (last_win == 0) ? 1 : 0;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        chk("req0_gnt", req0_gnt, longint'(win == 0));
        chk("req1_gnt", req1_gnt, longint'(win == 1));
        chk("out_valid", out_valid, longint'(rst_n && sz > 0));
        if (!rst_n || sz == 0) chk("out_data_idle", out_data, 0);
        chk("count", count, sz);
        chk("full", full, longint'(sz == DEPTH));
        chk("empty", empty, longint'(sz == 0));
        if (!rst_n) begin
            sb.delete();
            last_win = 1;
        end else if (flush) begin
            sb.delete();
        end else if (win >= 0) begin
            sb.push_back(win == 1 ? req1_data : req0_data);
            last_win = win;
            if (win == 0) clr0 = 1'b1;
            else          clr1 = 1'b1;
        end
    endtask

    // Monitor: every word the DUT hands to the consumer must be the oldest expected one.
    initial begin
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk_in);
            #2;
            if (rst_n && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop_underflow: got %0h expected no pop at %0t", out_data, $time);
                end else begin
                    exp = sb.pop_front();
                    chk("out_data", out_data, exp);
                end
            end
        end
    end

    initial begin
        repeat (2) step(100, 0, 100, 100);
        repeat (20)  step(0, 0, 0, 100);
        repeat (40)  step(100, 0, 0, 100);
        repeat (20)  step(0, 0, 0, 100);
        repeat (800) step(50, 3, 1, 70);
        repeat (800) step(20, 2, 1, 90);
        repeat (800) step(90, 2, 1, 40);
        repeat (30)  step(100, 0, 0, 0);
        @(negedge clk_in);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
